// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields, memory handshake and datapath control bundle
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct_3;
    logic       funct_7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;
    logic       illegal_instr;
    logic [3:0] state;

    modport master (
        input  opcode, funct_3, funct_7_5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src,
               illegal_instr, state
    );

    modport slave (
        output opcode, funct_3, funct_7_5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src,
               illegal_instr, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM for a shared-memory multi-cycle RV32I datapath
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multicycle_controller_if.master       ctl
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_e state_q, state_d;

    logic       alu_f3_ok, r_ok, br_ok;
    logic [2:0] alu_op;
    logic       mem_req, mem_write, adr_src, ir_wr, pc_wr, reg_wr, illegal;
    logic [1:0] result_src, src_a, src_b, imm_src;
    logic [2:0] alu_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= state_e'(RESET_STATE);
        else        state_q <= state_d;
    end

    // Only add/slt/or/and are implemented; R-type funct_7_5 may only select sub.
    assign alu_f3_ok = (ctl.funct_3 == 3'b000) || (ctl.funct_3 == 3'b010) ||
                       (ctl.funct_3 == 3'b110) || (ctl.funct_3 == 3'b111);
    assign r_ok      = alu_f3_ok && !(ctl.funct_7_5 && (ctl.funct_3 != 3'b000));
    assign br_ok     = (ctl.funct_3[2:1] == 2'b00);

    always_comb begin
        alu_op = ALU_ADD;
        case (ctl.funct_3)
            3'b000:  alu_op = (ctl.opcode == OP_R && ctl.funct_7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (ctl.opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BR:   imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        reg_wr     = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_ctrl   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                ir_wr      = ctl.mem_ready;
                pc_wr      = ctl.mem_ready;
                if (ctl.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (ctl.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = r_ok ? S_EXECR : S_TRAP;
                    OP_I:         state_d = alu_f3_ok ? S_EXECI : S_TRAP;
                    OP_BR:        state_d = br_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = (ctl.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ctl.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_wr     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (ctl.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a    = 2'b10;
                alu_ctrl = alu_op;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                src_a    = 2'b10;
                src_b    = 2'b01;
                alu_ctrl = alu_op;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                src_a    = 2'b10;
                alu_ctrl = ALU_SUB;
                // funct_3[0] inverts the sense: beq takes on zero, bne on non-zero.
                pc_wr    = ctl.zero ^ ctl.funct_3[0];
                state_d  = S_FETCH;
            end
            S_JAL: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                pc_wr   = 1'b1;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked by rst_n so a Mealy fetch completion cannot fire while reset is held.
    assign ctl.ir_write      = ir_wr  & rst_n;
    assign ctl.pc_write      = pc_wr  & rst_n;
    assign ctl.reg_write     = reg_wr & rst_n;
    assign ctl.mem_req       = mem_req;
    assign ctl.mem_write     = mem_write;
    assign ctl.adr_src       = adr_src;
    assign ctl.result_src    = result_src;
    assign ctl.alu_src_a     = src_a;
    assign ctl.alu_src_b     = src_b;
    assign ctl.alu_ctrl      = alu_ctrl;
    assign ctl.imm_src       = imm_src;
    assign ctl.illegal_instr = illegal;
    assign ctl.state         = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller with a per-instruction reference model
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller #(.RESET_STATE(4'd0)) dut (.clk(clk), .rst_n(rst_n), .ctl(bus));

    logic [21:0] exp_q[$];
    string       name_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    logic        cur_taken;
    logic [2:0]  cur_alu;
    logic [1:0]  cur_imm;
    logic [21:0] mon_exp, mon_got;
    string       mon_name;

    // Expected outputs of a step, straight from the per-state output table.
    function automatic logic [21:0] model_out(int st, bit rdy, bit taken, logic [2:0] alu, logic [1:0] imm);
        logic       mreq = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 0, a = 0, b = 0;
        logic [2:0] ac = 3'b000;
        case (st)
            0:  begin mreq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  begin mreq = 1; adr = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin mreq = 1; mw = 1; adr = 1; end
            6:  begin a = 2'b10; b = 2'b00; ac = alu; end
            7:  begin a = 2'b10; b = 2'b01; ac = alu; end
            8:  begin rw = 1; end
            9:  begin a = 2'b10; ac = 3'b001; pcw = taken; end
            10: begin a = 2'b01; b = 2'b10; pcw = 1; end
            11: begin ill = 1; end
            default: ;
        endcase
        return {4'(st), mreq, mw, adr, irw, pcw, rw, rs, a, b, ac, imm, ill};
    endfunction

    function automatic logic [21:0] sample_dut();
        return {bus.state, bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
                bus.imm_src, bus.illegal_instr};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = sample_dut();
            vectors++;
            if (mon_got !== mon_exp) begin
                miscompares++;
                $display("FAIL %s t=%0t: got %h required %h", mon_name, $time, mon_got, mon_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic step(string nm, int st, bit rdy);
        bus.mem_ready = rdy;
        exp_q.push_back(model_out(st, rdy, cur_taken, cur_alu, cur_imm));
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic reset_step();
        bus.mem_ready = 1'b1;
        exp_q.push_back(model_out(0, 1'b0, 1'b0, 3'b000, cur_imm));
        name_q.push_back("reset");
        @(posedge clk); #1;
    endtask

    task automatic mem_state(string nm, int st, int waits);
        repeat (waits) step(nm, st, 1'b0);
        step(nm, st, 1'b1);
    endtask

    task automatic plain(string nm, int st);
        step(nm, st, 1'($urandom_range(0, 1)));
    endtask

    function automatic bit legal_opcode(logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
    endfunction

    // kind: 0 add,1 sub,2 slt,3 or,4 and,5 addi,6 slti,7 ori,8 andi,9 lw,10 sw,11 beq,12 bne,13 jal,
    //       14 bad opcode,15 R bad f3,16 R f75 with f3!=0,17 I bad f3,18 branch bad f3
    task automatic setup_instr(int kind, bit zero, output int cls);
        logic [2:0] bad_f3[4] = '{3'b001, 3'b011, 3'b100, 3'b101};
        logic [2:0] alu_f3[4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        logic [2:0] alu_code[4] = '{3'b000, 3'b101, 3'b011, 3'b010};
        logic [6:0] op;
        bus.zero      = zero;
        bus.funct_7_5 = 1'($urandom_range(0, 1));
        bus.funct_3   = 3'($urandom_range(0, 7));
        cur_alu   = 3'b000;
        cur_taken = 1'b0;
        cur_imm   = 2'b00;
        cls       = 6;
        if (kind <= 4) begin
            bus.opcode = 7'b0110011; cls = 0;
            bus.funct_7_5 = (kind == 1);
            bus.funct_3 = (kind <= 1) ? 3'b000 : alu_f3[kind - 1];
            cur_alu = (kind == 1) ? 3'b001 : alu_code[(kind <= 1) ? 0 : kind - 1];
        end else if (kind <= 8) begin
            bus.opcode = 7'b0010011; cls = 1;
            bus.funct_3 = alu_f3[kind - 5];
            cur_alu = alu_code[kind - 5];
        end else if (kind == 9) begin
            bus.opcode = 7'b0000011; bus.funct_3 = 3'b010; cls = 2;
        end else if (kind == 10) begin
            bus.opcode = 7'b0100011; bus.funct_3 = 3'b010; cls = 3; cur_imm = 2'b01;
        end else if (kind == 11 || kind == 12) begin
            bus.opcode = 7'b1100011; cls = 4; cur_imm = 2'b10;
            bus.funct_3 = (kind == 11) ? 3'b000 : 3'b001;
            cur_taken = (kind == 11) ? zero : !zero;
        end else if (kind == 13) begin
            bus.opcode = 7'b1101111; cls = 5; cur_imm = 2'b11;
        end else if (kind == 14) begin
            do op = 7'($urandom_range(0, 127)); while (legal_opcode(op));
            bus.opcode = op;
        end else if (kind == 15) begin
            bus.opcode = 7'b0110011; bus.funct_3 = bad_f3[$urandom_range(0, 3)];
        end else if (kind == 16) begin
            bus.opcode = 7'b0110011; bus.funct_7_5 = 1'b1;
            bus.funct_3 = alu_f3[$urandom_range(1, 3)];
        end else if (kind == 17) begin
            bus.opcode = 7'b0010011; bus.funct_3 = bad_f3[$urandom_range(0, 3)];
        end else begin
            bus.opcode = 7'b1100011; cur_imm = 2'b10;
            bus.funct_3 = 3'($urandom_range(2, 7));
        end
    endtask

    task automatic run_instr(int kind, bit zero, int fw, int mw);
        int cls;
        setup_instr(kind, zero, cls);
        mem_state("fetch", 0, fw);
        plain("decode", 1);
        case (cls)
            0: begin plain("execr", 6); plain("aluwb", 8); end
            1: begin plain("execi", 7); plain("aluwb", 8); end
            2: begin plain("memadr", 2); mem_state("memread", 3, mw); plain("memwb", 4); end
            3: begin plain("memadr", 2); mem_state("memwrite", 5, mw); end
            4: plain("branch", 9);
            5: begin plain("jal", 10); plain("aluwb", 8); end
            default: plain("trap", 11);
        endcase
    endtask

    initial begin
        int cls;
        rst_n = 1'b0;
        bus.opcode = 7'd0; bus.funct_3 = 3'd0; bus.funct_7_5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;
        cur_taken = 1'b0; cur_alu = 3'b000; cur_imm = 2'b00;
        @(posedge clk); #1;
        reset_step();
        reset_step();
        rst_n = 1'b1;

        run_instr(0, 1'b0, 0, 0);      // add
        run_instr(1, 1'b0, 0, 0);      // sub
        setup_instr(5, 1'b0, cls);     // addi with instr[30]=1 must stay add
        bus.funct_7_5 = 1'b1;
        mem_state("fetch", 0, 0); plain("decode", 1); plain("execi", 7); plain("aluwb", 8);
        run_instr(9, 1'b0, 0, 3);      // lw, three wait cycles
        run_instr(11, 1'b1, 1, 0);     // beq taken
        run_instr(12, 1'b1, 0, 0);     // bne not taken
        setup_instr(18, 1'b0, cls);
        bus.funct_3 = 3'b100;
        mem_state("fetch", 0, 0); plain("decode", 1); plain("trap", 11);
        setup_instr(14, 1'b0, cls);
        bus.opcode = 7'b0000000;
        mem_state("fetch", 0, 0); plain("decode", 1); plain("trap", 11);

        // Reset asserted while a store waits for memory.
        setup_instr(10, 1'b0, cls);
        mem_state("fetch", 0, 0); plain("decode", 1); plain("memadr", 2);
        step("memwrite", 5, 1'b0); step("memwrite", 5, 1'b0);
        #2;
        bus.mem_ready = 1'b1;
        bus.opcode = 7'd0;
        cur_imm = 2'b00;
        rst_n = 1'b0;
        #1;
        mon_got = sample_dut();
        vectors++;
        if (mon_got !== model_out(0, 1'b0, 1'b0, 3'b000, 2'b00)) begin
            miscompares++;
            $display("FAIL async_reset: got %h required %h", mon_got, model_out(0, 1'b0, 1'b0, 3'b000, 2'b00));
        end
        @(posedge clk); #1;
        reset_step();
        rst_n = 1'b1;
        run_instr(13, 1'b0, 0, 0);     // jal after reset release

        for (int i = 0; i < 300; i++) begin
            run_instr($urandom_range(0, 18), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected steps never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
